// File: rtl/pdh_pkg.sv
// Shared PDH loop definitions: DAC mid-scale code and the output-stage FSM states.
package pdh_pkg;

    localparam logic [13:0] DAC_MID = 14'd8192;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SLEW = 2'd1,
        LOCK = 2'd2,
        PARK = 2'd3
    } dac_slew_state_t;

endpackage

// File: rtl/posedge_detector.sv
// Rising-edge detector; the edge output is combinational from the input and its last sample.
module posedge_detector (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_c
);

    logic sig_prev;

    always_ff @(posedge clk) begin
        if (rst) sig_prev <= 1'b0;
        else     sig_prev <= sig_i;
    end

    assign rise_c = sig_i & ~sig_prev;

endmodule

// File: rtl/dac_slew_limiter.sv
// DAC output stage: clamps the PID code to a window, slew-limits it, ramps in/parks at mid-scale.
// Optional sustained-clamp detection is built when DAC_SLEW_RAIL_DETECT_EN is defined.
module dac_slew_limiter
    import pdh_pkg::*;
#(
    parameter int unsigned DAC_W      = 14,
    parameter int unsigned DEC_W      = 14,
    parameter int unsigned RAIL_TICKS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DAC_W-1:0] pid_i,
    input  logic             strobe_i,
    input  logic             enable_i,
    input  logic [DAC_W-1:0] step_i,
    input  logic [DAC_W-1:0] lo_i,
    input  logic [DAC_W-1:0] hi_i,
    input  logic [DEC_W-1:0] decimate_i,
    output logic [DAC_W-1:0] dac_o,
    output logic             at_target_o,
    output logic             rail_o,
    output logic [1:0]       state_o
);

    localparam logic [DAC_W-1:0] MID  = DAC_W'(DAC_MID);
    localparam logic [DAC_W-1:0] FULL = {DAC_W{1'b1}};

    logic strobe_rise_c;

    posedge_detector u_strobe_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (strobe_i),
        .rise_c (strobe_rise_c)
    );

    // Configuration shadow registers, loaded on the strobe rising edge
    logic             enable_r;
    logic [DAC_W-1:0] step_r;
    logic [DAC_W-1:0] lo_r;
    logic [DAC_W-1:0] hi_r;
    logic [DEC_W-1:0] dec_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_r <= 1'b0;
            step_r   <= '0;
            lo_r     <= '0;
            hi_r     <= FULL;
            dec_r    <= DEC_W'(1);
        end else if (strobe_rise_c) begin
            enable_r <= enable_i;
            step_r   <= step_i;
            lo_r     <= lo_i;
            hi_r     <= hi_i;
            dec_r    <= (decimate_i == '0) ? DEC_W'(1) : decimate_i;
        end
    end

    dac_slew_state_t state_q;
    dac_slew_state_t state_n;
    logic [DEC_W-1:0] cnt_q;
    logic             tick_c;

    assign tick_c = (cnt_q == '0) && (state_q != OFF);

    // Decimation counter, parked at zero in OFF so the first run tick is immediate
    always_ff @(posedge clk) begin
        if (rst || (state_q == OFF))      cnt_q <= '0;
        else if (cnt_q >= dec_r - DEC_W'(1)) cnt_q <= '0;
        else                              cnt_q <= cnt_q + DEC_W'(1);
    end

    logic [DAC_W-1:0]        lo_sel_c;
    logic [DAC_W-1:0]        target_c;
    logic [DAC_W-1:0]        dest_c;
    logic signed [DAC_W:0]   diff_c;
    logic [DAC_W:0]          mag_c;
    logic                    reach_c;
    logic [DAC_W-1:0]        stepped_c;
    logic [DAC_W-1:0]        slew_c;

    // An inverted window (lo > hi) naturally resolves to hi
    assign lo_sel_c  = (pid_i < lo_r) ? lo_r : pid_i;
    assign target_c  = (lo_sel_c > hi_r) ? hi_r : lo_sel_c;
    assign dest_c    = (state_q == PARK) ? MID : target_c;
    assign diff_c    = $signed({1'b0, dest_c}) - $signed({1'b0, dac_o});
    assign mag_c     = diff_c[DAC_W] ? $unsigned(-diff_c) : $unsigned(diff_c);
    assign reach_c   = (mag_c <= {1'b0, step_r}) || ((state_q == PARK) && (step_r == '0));
    assign stepped_c = diff_c[DAC_W] ? (dac_o - step_r) : (dac_o + step_r);
    assign slew_c    = reach_c ? dest_c : stepped_c;

    logic [DAC_W-1:0] dac_n;
    logic             at_target_n;

    // Next-state and next-output; a tick always uses the current state's rule
    always_comb begin
        state_n = state_q;
        dac_n   = dac_o;
        case (state_q)
            OFF: begin
                dac_n = MID;
                if (enable_r) state_n = SLEW;
            end
            SLEW, LOCK: begin
                if (tick_c) begin
                    dac_n   = slew_c;
                    state_n = reach_c ? LOCK : SLEW;
                end
                if (!enable_r) state_n = PARK;
            end
            PARK: begin
                if (tick_c) begin
                    dac_n = slew_c;
                    if (reach_c) state_n = OFF;
                end
                if (enable_r) state_n = SLEW;
            end
            default: begin
                dac_n   = MID;
                state_n = OFF;
            end
        endcase
        at_target_n = (state_n == LOCK) && (dac_n == target_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OFF;
            dac_o       <= MID;
            at_target_o <= 1'b0;
        end else begin
            state_q     <= state_n;
            dac_o       <= dac_n;
            at_target_o <= at_target_n;
        end
    end

    assign state_o = state_q;

`ifdef DAC_SLEW_RAIL_DETECT_EN
    localparam int unsigned      RAIL_W   = $clog2(RAIL_TICKS + 1);
    localparam logic [RAIL_W-1:0] RAIL_MAX = RAIL_W'(RAIL_TICKS);

    logic              clamped_c;
    logic [RAIL_W-1:0] rail_cnt;
    logic [RAIL_W-1:0] rail_cnt_n;

    assign clamped_c = (pid_i < lo_r) || (pid_i > hi_r);

    // Consecutive clamped ticks, saturating; any unclamped tick or OFF clears it
    always_comb begin
        rail_cnt_n = rail_cnt;
        if (state_q == OFF) begin
            rail_cnt_n = '0;
        end else if (tick_c) begin
            if (!clamped_c)                rail_cnt_n = '0;
            else if (rail_cnt != RAIL_MAX) rail_cnt_n = rail_cnt + RAIL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rail_cnt <= '0;
            rail_o   <= 1'b0;
        end else begin
            rail_cnt <= rail_cnt_n;
            rail_o   <= (rail_cnt_n >= RAIL_MAX);
        end
    end
`else
    logic rail_unused;
    assign rail_unused = ^RAIL_TICKS;
    assign rail_o      = 1'b0;
`endif

endmodule

// File: doc/dac_slew_limiter.md
# dac_slew_limiter

Output stage directly downstream of the PID core. Consumes the 14-bit offset-binary PID code (mid-scale 8192 = zero correction) and produces the DAC drive word. It clamps the code to a programmable window and limits the per-update slew. On enable it ramps in from mid-scale; on disable it parks back to mid-scale. It also flags sustained clamping (loss of lock / actuator at rail).

## Interface
Parameters:
- DAC_W, 14, DAC code width (offset binary).
- DEC_W, 14, decimation counter width.
- RAIL_TICKS, 1024, consecutive clamped update ticks before rail_o asserts.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- pid_i  in  DAC_W  PID output code, unsigned.
- strobe_i  in  1  config load; rising edge latches all *_i config inputs.
- enable_i  in  1  config: run (1) / park (0).
- step_i  in  DAC_W  config: max |Δ| per update tick.
- lo_i, hi_i  in  DAC_W  config: clamp window.
- decimate_i  in  DEC_W  config: update every N cycles; 0 is treated as 1.
- dac_o  out  DAC_W  registered DAC word.
- at_target_o  out  1  dac_o equals the clamped target while in LOCK.
- rail_o  out  1  sustained-clamp flag.
- state_o  out  2  current FSM state encoding.

## Operation
- Strobe edge detection:
  - edge = strobe_i & ~strobe_prev.
  - On the edge cycle, the config registers (enable_r, step_r, lo_r, hi_r, dec_r) load from the inputs.
  - rst overrides a coincident edge.
- Target computation: t1 = (pid_i < lo_r) ? lo_r : pid_i; target = (t1 > hi_r) ? hi_r : t1.
  - If lo_r > hi_r, target = hi_r.
  - clamped = (pid_i < lo_r) | (pid_i > hi_r).
- Tick generation:
  - cnt counts 0..dec_r-1 and wraps.
  - tick = (cnt == 0) & (state != OFF).
  - cnt is held at 0 in OFF.
- Slew rule, applied on tick:
  - diff = target − dac_o, computed at DAC_W+1 bits signed.
  - If |diff| ≤ step_r, then dac_o ← target.
  - Otherwise dac_o ← dac_o ± step_r, moving toward target.
  - Result is always within [0, 2^DAC_W−1]; no wrap.
  - step_r = 0 freezes dac_o, except in PARK (see below).
- FSM, transitions evaluated every cycle:
  - OFF → SLEW when enable_r = 1. In OFF, dac_o = 8192.
  - SLEW → LOCK on the tick where dac_o reaches target.
  - LOCK → SLEW on the tick where |diff| > step_r.
  - In LOCK, dac_o tracks target each tick.
  - SLEW or LOCK → PARK when enable_r = 0.
  - PARK slews toward 8192 using step_r. If step_r = 0, dac_o jumps to 8192 in one tick.
  - PARK → OFF on the tick where dac_o reaches 8192.
  - PARK → SLEW when enable_r = 1 again.
  - enable_r change and tick in the same cycle: the tick uses the old state's rule; the new state applies from the next cycle.
- at_target_o = (state == LOCK) & (dac_o == target), registered with dac_o.
- Rail counter:
  - On tick, increments (saturating at RAIL_TICKS) if clamped; otherwise clears.
  - rail_o = (count ≥ RAIL_TICKS).
  - Cleared in OFF.

## Timing
- Reset values:
  - dac_o = 8192, state OFF (2'd0), at_target_o = 0, rail_o = 0, cnt = 0.
  - enable_r = 0, step_r = 0, lo_r = 0, hi_r = 2^DAC_W−1, dec_r = 1.
- Config latency: registers valid 1 cycle after the edge cycle.
- OFF→SLEW takes effect the cycle after enable_r = 1. The first tick comes on that cycle, since cnt = 0.
- pid_i → dac_o: 1 cycle, registered, on tick cycles only. pid_i is sampled only on tick cycles.
- State encoding: OFF = 0, SLEW = 1, LOCK = 2, PARK = 3.
- Mid-operation reset returns all registers to reset values on the next edge. No ramp-down occurs.

## Configuration
- DAC_SLEW_RAIL_DETECT_EN:
  - Defined: the rail counter and rail_o logic are present as described.
  - Undefined: no counter is synthesized and rail_o is tied to 0.

## Structure
- Shared package pdh_pkg provides:
  - DAC_MID constant (14'd8192).
  - dac_slew_state_t enum {OFF, SLEW, LOCK, PARK}.
- Sub-module: posedge_detector, for strobe_i. It supplies the combinational edge only.

## Test plan
- Reset: assert rst 2 cycles → dac_o = 8192, state_o = 0, at_target_o = 0, rail_o = 0.
- Ramp-in:
  - Stimulus: strobe with enable = 1, step = 100, lo = 0, hi = 16383, dec = 1; pid_i = 9000.
  - Response: dac_o = 8292, 8392, …, 8992, then 9000 on the 9th tick. state_o = 2 and at_target_o = 1.
- Clamp: hi = 10000, step = 16383, pid_i = 16000 → dac_o = 10000 after 1 tick, LOCK, at_target_o = 1.
- Park:
  - Stimulus: from LOCK at 9000 with step = 100, strobe enable = 0.
  - Response: state_o = 3; dac_o = 8900 … 8200, then 8192 on the 9th tick; state_o = 0 the next cycle.
- Decimation: dec = 4, step = 1, pid_i = 9000 → dac_o changes only every 4th cycle (8193 at cycle 1, 8194 at cycle 5, …). decimate_i = 0 behaves as 1.
- Rail (macro defined, RAIL_TICKS = 8):
  - Stimulus: lo = 1000, pid_i = 0.
  - Response: rail_o = 1 after the 8th clamped tick. With pid_i = 5000 → rail_o = 0 one cycle after the next tick.
  - Macro undefined: rail_o is never 1.
